// File: rtl/tail_light_seq.sv
// Tail-light sequencer with N lamps per side and a built-in tick prescaler.
// Driver requests are sampled only on prescaler ticks. Each tick picks a mode
// by priority (alarm, hazard, left, right, brake, idle) and advances the
// pattern phase of that mode. Lamp outputs are registered and are computed
// from the next state, so they change on the tick edge with no extra latency.
module tail_light_seq #(
  parameter int N_LAMPS = 3,
  parameter int PRESC   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               brake,
  input  logic               alarm,
  output logic [N_LAMPS-1:0] l,
  output logic [N_LAMPS-1:0] r,
  output logic [2:0]         mode,
  output logic               tick
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int PW = $clog2(N_LAMPS + 1);

  localparam logic [CW-1:0]      CNT_LAST = CW'(PRESC - 1);
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]      PH_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0]      PH_ONE   = PW'(1);
  localparam logic [PW-1:0]      PH_LAST  = PW'(N_LAMPS);
  localparam logic [N_LAMPS-1:0] ALL_ON   = {N_LAMPS{1'b1}};
  localparam logic [N_LAMPS-1:0] ALL_OFF  = {N_LAMPS{1'b0}};

  typedef enum logic [2:0] {
    M_IDLE   = 3'd0,
    M_LEFT   = 3'd1,
    M_RIGHT  = 3'd2,
    M_BRAKE  = 3'd3,
    M_HAZARD = 3'd4,
    M_ALARM  = 3'd5
  } mode_e;

  logic [CW-1:0]      cnt_r;
  mode_e              mode_r;
  logic [PW-1:0]      phase_r;
  logic               brk_r;
  logic [N_LAMPS-1:0] l_r;
  logic [N_LAMPS-1:0] r_r;

  logic               tick_s;
  mode_e              req_s;
  logic               same_s;
  mode_e              mode_nxt_s;
  logic [PW-1:0]      phase_nxt_s;
  logic               brk_nxt_s;
  logic [CW-1:0]      cnt_nxt_s;
  logic [N_LAMPS-1:0] l_nxt_s;
  logic [N_LAMPS-1:0] r_nxt_s;

  // Thermometer code: the lowest 'ph' lamps lit, counted from the inner lamp.
  function automatic logic [N_LAMPS-1:0] thermo(input logic [PW-1:0] ph);
    logic [N_LAMPS-1:0] t;
    for (int i = 0; i < N_LAMPS; i++) begin
      t[i] = (ph > PW'(i));
    end
    return t;
  endfunction

  assign tick_s = (cnt_r == CNT_LAST);
  // Held low while reset is asserted; constant high for PRESC=1 otherwise.
  assign tick   = reset & tick_s;

  // Prescaler wrap and request priority encoder.
  always_comb begin
    cnt_nxt_s = tick_s ? CNT_ZERO : (cnt_r + CNT_ONE);
    if (alarm) begin
      req_s = M_ALARM;
    end else if (left && right) begin
      req_s = M_HAZARD;
    end else if (left) begin
      req_s = M_LEFT;
    end else if (right) begin
      req_s = M_RIGHT;
    end else if (brake) begin
      req_s = M_BRAKE;
    end else begin
      req_s = M_IDLE;
    end
    same_s = (req_s == mode_r);
  end

  // Next mode/phase/brake sample; state only moves on tick edges.
  always_comb begin
    mode_nxt_s  = mode_r;
    phase_nxt_s = phase_r;
    brk_nxt_s   = brk_r;
    if (tick_s) begin
      brk_nxt_s = brake;
      case (mode_r)
        M_LEFT, M_RIGHT: begin
          if (same_s) begin
            phase_nxt_s = (phase_r >= PH_LAST) ? PH_ZERO : (phase_r + PH_ONE);
          end else begin
            mode_nxt_s  = req_s;
            phase_nxt_s = PH_ONE;
          end
        end
        M_HAZARD, M_ALARM: begin
          if (same_s) begin
            phase_nxt_s = (phase_r == PH_ONE) ? PH_ZERO : PH_ONE;
          end else begin
            mode_nxt_s  = req_s;
            phase_nxt_s = PH_ONE;
          end
        end
        M_IDLE, M_BRAKE: begin
          if (same_s) begin
            phase_nxt_s = PH_ONE;
          end else begin
            mode_nxt_s  = req_s;
            phase_nxt_s = PH_ONE;
          end
        end
        default: begin
          // Unreachable encodings fall back to a quiet state.
          mode_nxt_s  = M_IDLE;
          phase_nxt_s = PH_ONE;
        end
      endcase
    end else begin
      mode_nxt_s  = mode_r;
      phase_nxt_s = phase_r;
    end
  end

  // Lamp pattern decoded from the next state, so it lands on the tick edge.
  always_comb begin
    l_nxt_s = ALL_OFF;
    r_nxt_s = ALL_OFF;
    case (mode_nxt_s)
      M_IDLE: begin
        l_nxt_s = ALL_OFF;
        r_nxt_s = ALL_OFF;
      end
      M_BRAKE: begin
        l_nxt_s = ALL_ON;
        r_nxt_s = ALL_ON;
      end
      M_LEFT: begin
        l_nxt_s = thermo(phase_nxt_s);
        r_nxt_s = brk_nxt_s ? ALL_ON : ALL_OFF;
      end
      M_RIGHT: begin
        l_nxt_s = brk_nxt_s ? ALL_ON : ALL_OFF;
        r_nxt_s = thermo(phase_nxt_s);
      end
      M_HAZARD: begin
        l_nxt_s = (phase_nxt_s == PH_ONE) ? ALL_ON : ALL_OFF;
        r_nxt_s = (phase_nxt_s == PH_ONE) ? ALL_ON : ALL_OFF;
      end
      M_ALARM: begin
        l_nxt_s = (phase_nxt_s == PH_ONE) ? ALL_ON : ALL_OFF;
        r_nxt_s = (phase_nxt_s == PH_ONE) ? ALL_OFF : ALL_ON;
      end
      default: begin
        l_nxt_s = ALL_OFF;
        r_nxt_s = ALL_OFF;
      end
    endcase
  end

  // Sequencer state, prescaler and registered lamp outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r   <= CNT_ZERO;
      mode_r  <= M_IDLE;
      phase_r <= PH_ZERO;
      brk_r   <= 1'b0;
      l_r     <= ALL_OFF;
      r_r     <= ALL_OFF;
    end else begin
      cnt_r   <= cnt_nxt_s;
      mode_r  <= mode_nxt_s;
      phase_r <= phase_nxt_s;
      brk_r   <= brk_nxt_s;
      l_r     <= l_nxt_s;
      r_r     <= r_nxt_s;
    end
  end

  assign l    = l_r;
  assign r    = r_r;
  assign mode = mode_r;

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: three configurations share one stimulus stream.
// A behavioural model predicts each tick edge's lamps and mode into a queue.
// A monitor pops from the queue whenever the DUT has presented a tick.
module tb_tail_light_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, left, right, brake, alarm;
  logic [2:0] l0, r0, l1, r1, m0, m1, m2;
  logic [4:0] l2, r2;
  logic       t0, t1, t2;

  tail_light_seq #(.N_LAMPS(3), .PRESC(1)) u0 (.clk(clk), .reset(reset), .left(left), .right(right),
    .brake(brake), .alarm(alarm), .l(l0), .r(r0), .mode(m0), .tick(t0));
  tail_light_seq #(.N_LAMPS(3), .PRESC(4)) u1 (.clk(clk), .reset(reset), .left(left), .right(right),
    .brake(brake), .alarm(alarm), .l(l1), .r(r1), .mode(m1), .tick(t1));
  tail_light_seq #(.N_LAMPS(5), .PRESC(2)) u2 (.clk(clk), .reset(reset), .left(left), .right(right),
    .brake(brake), .alarm(alarm), .l(l2), .r(r2), .mode(m2), .tick(t2));

  typedef struct packed {
    logic [2:0] mode;
    logic [4:0] l;
    logic [4:0] r;
  } exp_t;

  exp_t oq[3][$];
  bit   tq[3][$];
  exp_t last_exp[3];
  bit   last_tick[3];
  bit   last_push_tick[3];

  int npar[3] = '{3, 3, 5};
  int ppar[3] = '{1, 4, 2};
  int m_mode[3], m_step[3], e_cnt[3];
  bit m_brk[3];

  int checks = 0;
  int passed = 0;
  bit running = 1'b1;

  function automatic exp_t obs(input int i);
    exp_t o;
    case (i)
      0: o = '{mode: m0, l: {2'b00, l0}, r: {2'b00, r0}};
      1: o = '{mode: m1, l: {2'b00, l1}, r: {2'b00, r1}};
      default: o = '{mode: m2, l: l2, r: r2};
    endcase
    return o;
  endfunction

  function automatic bit obs_tick(input int i);
    case (i)
      0: return t0;
      1: return t1;
      default: return t2;
    endcase
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s inst%0d: got %h expected %h at %0t", name, i, act, exp, $time);
  endtask

  task automatic fail_note(input string name, input int i);
    checks++;
    $display("FAIL %s inst%0d: queue empty at %0t", name, i, $time);
  endtask

  // Behavioural model: count steps spent in a mode and derive the pattern.
  task automatic step(input int i, input bit a, input bit lf, input bit rt, input bit br);
    int req, full, k, lv, rv;
    exp_t e;
    req = a ? 5 : (lf && rt) ? 4 : lf ? 1 : rt ? 2 : br ? 3 : 0;
    if (req == m_mode[i]) m_step[i]++;
    else begin
      m_mode[i] = req;
      m_step[i] = 0;
    end
    m_brk[i] = br;
    full = (1 << npar[i]) - 1;
    k = (m_step[i] + 1) % (npar[i] + 1);
    case (m_mode[i])
      1: begin lv = (1 << k) - 1; rv = m_brk[i] ? full : 0; end
      2: begin rv = (1 << k) - 1; lv = m_brk[i] ? full : 0; end
      3: begin lv = full; rv = full; end
      4: begin lv = (m_step[i] % 2 == 0) ? full : 0; rv = lv; end
      5: begin lv = (m_step[i] % 2 == 0) ? full : 0; rv = (m_step[i] % 2 == 0) ? 0 : full; end
      default: begin lv = 0; rv = 0; end
    endcase
    e.mode = 3'(m_mode[i]);
    e.l = 5'(lv);
    e.r = 5'(rv);
    oq[i].push_back(e);
  endtask

  // One clock of stimulus, driven at the falling edge, with predictions pushed.
  task automatic cyc(input bit rs, input bit a, input bit lf, input bit rt, input bit br);
    bit tk;
    @(negedge clk);
    reset = rs; alarm = a; left = lf; right = rt; brake = br;
    for (int i = 0; i < 3; i++) begin
      if (!rs) begin
        e_cnt[i] = 0; m_mode[i] = 0; m_step[i] = 0; m_brk[i] = 1'b0;
        tq[i].push_back(1'b0);
        last_push_tick[i] = 1'b0;
      end else begin
        e_cnt[i]++;
        tk = (e_cnt[i] % ppar[i] == 0);
        tq[i].push_back(tk);
        if (tk) step(i, a, lf, rt, br);
        last_push_tick[i] = tk;
      end
    end
  endtask

  // Monitor: after each tick edge take the next prediction; check every cycle.
  always @(negedge clk) begin
    #2;
    if (running) begin
      for (int i = 0; i < 3; i++) begin
        if (!reset) begin
          oq[i].delete();
          last_exp[i] = '0;
          last_tick[i] = 1'b0;
        end else if (last_tick[i]) begin
          if (oq[i].size() == 0) fail_note("lamp_queue", i);
          else last_exp[i] = oq[i].pop_front();
        end
        check("mode_lamps", i, 32'(obs(i)), 32'(last_exp[i]));
        if (tq[i].size() == 0) fail_note("tick_queue", i);
        else check("tick", i, 32'(obs_tick(i)), 32'(tq[i].pop_front()));
        last_tick[i] = obs_tick(i);
      end
    end
  end

  initial begin
    bit a, lf, rt, br;
    int n;
    reset = 1'b0; left = 1'b0; right = 1'b0; brake = 1'b0; alarm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      last_exp[i] = '0; last_tick[i] = 1'b0; last_push_tick[i] = 1'b0;
      m_mode[i] = 0; m_step[i] = 0; e_cnt[i] = 0; m_brk[i] = 1'b0;
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Left sweep, then a fresh sweep with brake from its third tick.
    repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // Hazard then alarm.
    repeat (4) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // Asynchronous reset mid-sweep while inst0 shows 011.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("async_rst_l", 0, 32'(l0), 32'd0);
    check("async_rst_r", 0, 32'(r0), 32'd0);
    check("async_rst_mode", 0, 32'(m0), 32'd0);
    check("async_rst_l", 2, 32'(l2), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Left held with a single one-clock right pulse away from inst1 ticks.
    for (int k = 0; k < 12; k++) begin
      rt = (k >= 4) && ((e_cnt[1] + 1) % 4 == 2) && (k < 8);
      cyc(1'b1, 1'b0, 1'b1, rt, 1'b0);
    end
    // Right sweep, then brake alone.
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Randomised held requests with occasional resets.
    for (int k = 0; k < 80; k++) begin
      a  = ($urandom_range(0, 7) == 0);
      lf = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 9);
      if ($urandom_range(0, 19) == 0) cyc(1'b0, a, lf, rt, br);
      repeat (n) cyc(1'b1, a, lf, rt, br);
    end
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #4;
    running = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("tail_lamp_queue", i, 32'(oq[i].size()), last_push_tick[i] ? 32'd1 : 32'd0);
      check("tail_tick_queue", i, 32'(tq[i].size()), 32'd0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
